ap_load_scheduler: RTL and testbench
====================================

Name: ap_load_scheduler

Overview:
- Round-robin scheduler that shares one 60-bit activation-package serial loader between NUM_REQ requesters.
- Accepts a parallel package from the winning requester and serializes it MSB-first onto the loader's serial input.
- Flags the single cycle in which the loader's parallel output holds the complete package.
- Sits between the activation sources and the serial-in/parallel-out activation package register in the NOC datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PKT_W, 60, package width in bits; equals the loader register width.
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  when high, scheduler may accept new packages
- req_valid  input  NUM_REQ  per-requester package valid
- req_data  input  NUM_REQ*PKT_W  packed packages; requester i occupies bits [i*PKT_W +: PKT_W]
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- serial_out  output  1  drives the loader serial_in
- busy  output  1  high in SHIFT and DONE
- pkt_done  output  1  one-cycle pulse; loader parallel output equals the accepted package this cycle
- pkt_src  output  ID_W  index of the requester whose package is in the loader; valid with pkt_done

Behaviour:
Reset and state:
- Reset is asynchronous and active-high; there is one clock, clk.
- Reset values: state=IDLE, shadow=0, bit counter=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- Reset values of outputs: req_ready=0, serial_out=0, busy=0, pkt_done=0, pkt_src=0.
- FSM states: IDLE, SHIFT, DONE.

IDLE:
- busy=0, serial_out=0.
- If en=1 and any req_valid is set, req_ready is combinationally one-hot on the first valid requester searching from last_grant+1 modulo NUM_REQ.
- On that edge: latch req_data of the winner into the shadow register, set last_grant=winner, clear counter, move to SHIFT.
- If en=0 or no req_valid is set, req_ready=0 and the FSM stays in IDLE.
- req_ready is never asserted outside IDLE.

SHIFT:
- busy=1.
- serial_out = shadow[PKT_W-1], combinational from the shadow register.
- Each cycle: shadow shifts left one bit with 0 fill, counter increments.
- When counter == PKT_W-1 the FSM moves to DONE.
- The loader samples on the same edges, so after exactly PKT_W shift cycles its register equals the accepted package, with the first bit sent (package MSB) at the top position.

DONE:
- Lasts one cycle. busy=1, pkt_done=1, pkt_src=last_grant, serial_out=0.
- Next state is IDLE.
- The loader shifts continuously and its output is corrupted after this cycle; consumers must capture on pkt_done only.

Timing and throughput:
- Latency from acceptance edge to pkt_done is PKT_W+1 cycles: 60 shift cycles, then pkt_done high in the following cycle.
- Throughput is one package every PKT_W+2 cycles under continuous requests.

Boundary conditions:
- Simultaneous requests: strict round-robin. With all requesters valid, the grant order after reset is 0,1,2,3,0,...
- A requester that drops req_valid before it is granted loses nothing; no state is retained for it.
- Data is captured at acceptance; req_data may change during SHIFT with no effect.
- en falling during SHIFT or DONE does not abort the package in flight; it only blocks the next acceptance.
- Reset during SHIFT or DONE: immediate return to IDLE, no pkt_done, and last_grant returns to NUM_REQ-1.
- A package of all zeros or all ones is serialized normally; no special-casing.

Test Plan:
- Reset release, req_valid[0]=1, req_data[0]=60'hA5A_5A5A_5A5A_5A5A -> req_ready=0001 for 1 cycle; pkt_done exactly 61 cycles after the accept edge; loader output = 60'hA5A5A5A5A5A5A5A; pkt_src=0.
- All four req_valid held high with distinct data -> grant order 0,1,2,3,0; pkt_done pulses spaced 62 cycles apart; each pkt_src matches the loader contents.
- Reset asserted 30 cycles into SHIFT, then released with only req_valid[2]=1 -> no pkt_done for the aborted package; requester 2 granted; the next package completes intact.
- en=0 with req_valid=1111 -> req_ready stays 0000 and busy=0. Raise en -> requester 0 granted the next cycle.
- req_data changed every cycle during SHIFT -> loader output on pkt_done equals the data sampled at acceptance.
- Alternating-bit package 60'h555_5555_5555_5555 -> serial_out sequence 0,1,0,1,... (first bit is bit 59 = 0); busy high for 61 cycles.

Source files
------------

// File: rtl/ap_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ap_load_scheduler
// Purpose  : Round-robin scheduler sharing one activation-package serial
//            loader between NUM_REQ requesters. The winning requester's
//            package is captured into a shadow register, then shifted out
//            MSB-first, one bit per cycle. After PKT_W shift cycles the
//            downstream serial-in/parallel-out loader holds the package,
//            and pkt_done marks that single cycle.
// Ports    :
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   en          in   allows acceptance of a new package
//   req_valid   in   [NUM_REQ]        per-requester package valid
//   req_data    in   [NUM_REQ*PKT_W]  requester i at [i*PKT_W +: PKT_W]
//   req_ready   out  [NUM_REQ]        one-hot grant (IDLE only)
//   serial_out  out  loader serial input
//   busy        out  high while shifting and during the done cycle
//   pkt_done    out  one-cycle pulse, loader output equals the package
//   pkt_src     out  [ID_W] source requester, valid with pkt_done
// Revision : 1.0 - initial release
// ============================================================================
module ap_load_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = 60,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     pkt_done,
  output logic [ID_W-1:0]          pkt_src
);

  localparam int CNT_W = $clog2(PKT_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;

  // Round-robin search result
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      rr_cand;
  logic [PKT_W-1:0]   win_data;

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester starting at last_grant+1.
  // last_grant < NUM_REQ and k <= NUM_REQ, so one conditional subtraction
  // is enough for the modulo; the extra bit in rr_cand holds the carry.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (rr_cand >= (ID_W+1)'(NUM_REQ)) begin
        rr_cand = rr_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[rr_cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_cand[ID_W-1:0];
      end
    end
  end

  // Winner data mux, written as a compare-select to avoid a computed slice.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_data = req_data[i*PKT_W +: PKT_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ-1);
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    serial_out   = 1'b0;
    busy         = 1'b0;
    pkt_done     = 1'b0;
    pkt_src      = '0;

    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while reset is held so req_ready reads 0
        // even though the asynchronous reset leaves the FSM in IDLE.
        if (en && win_found && !reset) begin
          req_ready    = NUM_REQ'(1) << win_idx;
          shadow_d     = win_data;
          last_grant_d = win_idx;
          cnt_d        = '0;
          state_d      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy       = 1'b1;
        serial_out = shadow_q[PKT_W-1];
        shadow_d   = {shadow_q[PKT_W-2:0], 1'b0};
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PKT_W-1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Loader contents are only valid in this cycle; it keeps shifting.
        busy     = 1'b1;
        pkt_done = 1'b1;
        pkt_src  = last_grant_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ap_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_load_scheduler
// Purpose  : Self-checking bench for ap_load_scheduler. Models the external
//            serial-in/parallel-out loader and compares the DUT against a
//            transaction-timeline reference model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ap_load_scheduler;

  localparam int N  = 4;
  localparam int W  = 60;
  localparam int IW = 2;

  logic             clk;
  logic             reset;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             serial_out;
  logic             busy;
  logic             pkt_done;
  logic [IW-1:0]    pkt_src;

  ap_load_scheduler #(.NUM_REQ(N), .PKT_W(W), .ID_W(IW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_src    (pkt_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream loader: shifts serial_out in on every rising edge.
  logic [W-1:0] loader;
  initial loader = '0;
  always @(posedge clk) loader <= {loader[W-2:0], serial_out};

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since acceptance (0 = no package in flight).
  int           m_t   = 0;
  int           m_lg  = N-1;
  int           m_src = 0;
  logic [W-1:0] m_pkt = '0;
  int           m_done_cnt = 0;
  int           dut_done_cnt = 0;
  int           grants[$];

  function automatic int rr_pick(input int lg, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < (N*W+31)/32; i++) begin
      d = {d[N*W-33:0], 32'($urandom)};
    end
    return d;
  endfunction

  // One clock cycle: drive at negedge, check 1ns later, advance the model.
  task automatic step(input logic e, input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
    int            w;
    logic [N-1:0]  exp_ready;
    @(negedge clk);
    en        = e;
    req_valid = v;
    req_data  = d;
    reset     = r;
    #1;
    dut_done_cnt += int'(pkt_done);
    if (r) begin
      check_val("rst_ready", 64'(req_ready), 64'(0));
      check_val("rst_busy",  64'(busy),      64'(0));
      check_val("rst_ser",   64'(serial_out), 64'(0));
      check_val("rst_done",  64'(pkt_done),  64'(0));
      check_val("rst_src",   64'(pkt_src),   64'(0));
      m_t  = 0;
      m_lg = N-1;
    end else if (m_t == 0) begin
      exp_ready = '0;
      w = -1;
      if (e && v != '0) begin
        w = rr_pick(m_lg, v);
        exp_ready = N'(1) << w;
      end
      check_val("idle_ready", 64'(req_ready), 64'(exp_ready));
      check_val("idle_busy",  64'(busy),      64'(0));
      check_val("idle_ser",   64'(serial_out), 64'(0));
      check_val("idle_done",  64'(pkt_done),  64'(0));
      if (w >= 0) begin
        m_pkt = d[w*W +: W];
        m_src = w;
        m_lg  = w;
        m_t   = 1;
        grants.push_back(w);
      end
    end else if (m_t <= W) begin
      check_val("shift_ready", 64'(req_ready), 64'(0));
      check_val("shift_busy",  64'(busy),      64'(1));
      check_val("shift_ser",   64'(serial_out), 64'(m_pkt[W - m_t]));
      check_val("shift_done",  64'(pkt_done),  64'(0));
      m_t++;
    end else begin
      check_val("done_ready",  64'(req_ready), 64'(0));
      check_val("done_busy",   64'(busy),      64'(1));
      check_val("done_ser",    64'(serial_out), 64'(0));
      check_val("done_pulse",  64'(pkt_done),  64'(1));
      check_val("done_loader", 64'(loader),    64'(m_pkt));
      check_val("done_src",    64'(pkt_src),   64'(m_src));
      m_done_cnt++;
      m_t = 0;
    end
  endtask

  task automatic run(input int n, input logic e, input logic [N-1:0] v, input logic [N*W-1:0] d);
    for (int i = 0; i < n; i++) step(e, v, d, 1'b0);
  endtask

  // Same as run but with fresh random data every cycle.
  task automatic run_rd(input int n, input logic e, input logic [N-1:0] v);
    for (int i = 0; i < n; i++) step(e, v, rand_data(), 1'b0);
  endtask

  logic [N*W-1:0] d0;
  logic [W-1:0]   pk;

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_data  = '0;
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 4'b1111, rand_data(), 1'b1);

    // Single requester 0 with the A5A pattern
    d0 = '0;
    d0[0 +: W] = 60'hA5A_5A5A_5A5A_5A5A;
    run(W + 2, 1'b1, 4'b0001, d0);
    check_val("a5a_grant", 64'(grants.size()), 64'(1));
    run(3, 1'b0, '0, '0);

    // All four valid: strict round-robin from requester 0
    step(1'b0, '0, '0, 1'b1);
    grants.delete();
    d0 = {60'hDDD_DDDD_0000_1234, 60'hCCC_0000_FFFF_0003,
          60'hBBB_1111_2222_3333, 60'hAAA_0123_4567_89AB};
    run(5 * (W + 2), 1'b1, 4'b1111, d0);
    check_val("rr_count", 64'(grants.size()), 64'(5));
    for (int i = 0; i < grants.size() && i < 5; i++) begin
      check_val("rr_order", 64'(grants[i]), 64'(i % N));
    end

    // Reset 30 cycles into a shift, then only requester 2
    step(1'b0, '0, '0, 1'b1);
    run(31, 1'b1, 4'b0001, rand_data());
    step(1'b1, 4'b0001, '0, 1'b1);
    step(1'b1, 4'b0001, '0, 1'b1);
    grants.delete();
    run_rd(W + 2, 1'b1, 4'b0100);
    check_val("abort_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'(2));

    // en low blocks grants, then requester 0 wins once en rises
    step(1'b0, '0, '0, 1'b1);
    grants.delete();
    run_rd(8, 1'b0, 4'b1111);
    check_val("en_blocked", 64'(grants.size()), 64'(0));
    run_rd(W + 2, 1'b1, 4'b1111);
    check_val("en_grant0", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));

    // Alternating-bit package, data churning during shift
    step(1'b0, '0, '0, 1'b1);
    d0 = rand_data();
    d0[W +: W] = 60'h555_5555_5555_5555;
    step(1'b1, 4'b0010, d0, 1'b0);
    run_rd(W + 3, 1'b0, 4'b0010);

    // All-zero and all-one packages
    d0 = '0;
    d0[3*W +: W] = '1;
    run(2 * (W + 2) + 2, 1'b1, 4'b1001, d0);

    // Randomized phase, occasional reset
    for (int i = 0; i < 6000; i++) begin
      step(($urandom % 8) != 0, N'($urandom), rand_data(), ($urandom % 300) == 0);
    end
    run(W + 3, 1'b0, '0, '0);

    check_val("done_total", 64'(dut_done_cnt), 64'(m_done_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
